// File: rtl/mdu_divider.sv
// Iterative restoring divider for DIV/DIVU: quotient to LO, remainder to HI, WIDTH+1 cycle latency.
// Optional MDU_DIV_ZERO_FAST_EN: a zero divisor skips the iteration and completes one cycle after start.
module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

`ifdef MDU_DIV_ZERO_FAST_EN
    localparam logic ZERO_FAST = 1'b1;
`else
    localparam logic ZERO_FAST = 1'b0;
`endif

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem_p;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] orig_dvd;
    logic             q_neg;
    logic             r_neg;
    logic             dz;

    logic             dvd_neg;
    logic             dvs_neg;
    logic             dvs_zero;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             no_borrow;

    always_comb begin
        dvd_neg   = is_signed & dividend[WIDTH-1];
        dvs_neg   = is_signed & divisor[WIDTH-1];
        dvs_zero  = (divisor == '0);
        dvd_mag   = dvd_neg ? (~dividend + 1'b1) : dividend;
        dvs_mag   = dvs_neg ? (~divisor + 1'b1) : divisor;
        // One extra bit above the WIDTH+1 partial remainder exposes the borrow of the trial subtract.
        shifted   = {rem_p, quo[WIDTH-1]};
        diff      = shifted - {2'b00, dvs};
        no_borrow = ~diff[WIDTH+1];
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            rem_p       <= '0;
            quo         <= '0;
            dvs         <= '0;
            orig_dvd    <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        quo      <= dvd_mag;
                        dvs      <= dvs_mag;
                        orig_dvd <= dividend;
                        q_neg    <= dvd_neg ^ dvs_neg;
                        r_neg    <= dvd_neg;
                        dz       <= dvs_zero;
                        rem_p    <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= (ZERO_FAST && dvs_zero) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    rem_p <= no_borrow ? diff[WIDTH:0] : shifted[WIDTH:0];
                    quo   <= {quo[WIDTH-2:0], no_borrow};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // A zero divisor reports the raw dividend untouched by the sign fix.
                    if (dz) begin
                        quotient  <= '1;
                        remainder <= orig_dvd;
                    end else begin
                        quotient  <= q_neg ? (~quo + 1'b1) : quo;
                        remainder <= r_neg ? (~rem_p[WIDTH-1:0] + 1'b1) : rem_p[WIDTH-1:0];
                    end
                    div_by_zero <= dz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_divider.sv
// Directed bench for mdu_divider: hand-computed DIV/DIVU vectors, latency, disturbances and reset abort.
module tb_mdu_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;
    int lat;
    int done_seen;

`ifdef MDU_DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    mdu_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Start is held across exactly one rising edge (E0); returns 1 time unit after E0.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after E0 until done; optionally raises a stray start (9/3) before edge 'inject'.
    task automatic wait_done(input int inject, output int n);
        n = 0;
        while (!done && n < 100) begin
            if (n + 1 == inject) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_quo", quotient, 32'd0);
        check("rst_rem", remainder, 32'd0);
        check("rst_dz", {31'b0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // DIVU 100 / 7
        issue(1'b0, 32'd100, 32'd7);
        check("divu_busy_e0", {31'b0, busy}, 32'd1);
        wait_done(0, lat);
        check("divu_lat", 32'(lat), 32'd33);
        check("divu_busy_done", {31'b0, busy}, 32'd0);
        check("divu_quo", quotient, 32'd14);
        check("divu_rem", remainder, 32'd2);
        check("divu_dz", {31'b0, div_by_zero}, 32'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'b0, done}, 32'd0);

        // DIV -7 / 2, results of the previous op must hold while busy
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        check("hold_quo", quotient, 32'd14);
        wait_done(0, lat);
        check("div_neg_dvd_quo", quotient, 32'hFFFF_FFFD);
        check("div_neg_dvd_rem", remainder, 32'hFFFF_FFFF);

        // DIV 7 / -2
        issue(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done(0, lat);
        check("div_neg_dvs_quo", quotient, 32'hFFFF_FFFD);
        check("div_neg_dvs_rem", remainder, 32'd1);

        // Most negative over -1, signed then unsigned
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, lat);
        check("ovf_div_quo", quotient, 32'h8000_0000);
        check("ovf_div_rem", remainder, 32'd0);
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, lat);
        check("ovf_divu_quo", quotient, 32'd0);
        check("ovf_divu_rem", remainder, 32'h8000_0000);

        // Divide by zero, signed positive and signed negative dividends
        issue(1'b1, 32'h1234_5678, 32'd0);
        wait_done(0, lat);
        check("dz_lat", 32'(lat), 32'(ZERO_LAT));
        check("dz_quo", quotient, 32'hFFFF_FFFF);
        check("dz_rem", remainder, 32'h1234_5678);
        check("dz_flag", {31'b0, div_by_zero}, 32'd1);
        issue(1'b1, 32'hFFFF_FFF9, 32'd0);
        wait_done(0, lat);
        check("dz_neg_quo", quotient, 32'hFFFF_FFFF);
        check("dz_neg_rem", remainder, 32'hFFFF_FFF9);
        check("dz_neg_flag", {31'b0, div_by_zero}, 32'd1);

        // DIVU 50 / 5 with a stray start (9/3) at cycle 10, then back-to-back 1000 / 3
        issue(1'b0, 32'd50, 32'd5);
        wait_done(10, lat);
        check("ignore_lat", 32'(lat), 32'd33);
        check("ignore_quo", quotient, 32'd10);
        check("ignore_rem", remainder, 32'd0);
        check("ignore_dz", {31'b0, div_by_zero}, 32'd0);
        issue(1'b0, 32'd1000, 32'd3);
        check("b2b_busy", {31'b0, busy}, 32'd1);
        wait_done(0, lat);
        check("b2b_lat", 32'(lat), 32'd33);
        check("b2b_quo", quotient, 32'd333);
        check("b2b_rem", remainder, 32'd1);

        // Make div_by_zero nonzero, then abort a DIVU with reset at cycle 15
        issue(1'b0, 32'd5, 32'd0);
        wait_done(0, lat);
        issue(1'b0, 32'd77, 32'd4);
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_quo", quotient, 32'd0);
        check("abort_rem", remainder, 32'd0);
        check("abort_dz", {31'b0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        issue(1'b0, 32'd77, 32'd4);
        wait_done(0, lat);
        check("after_abort_lat", 32'(lat), 32'd33);
        check("after_abort_quo", quotient, 32'd19);
        check("after_abort_rem", remainder, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_divider.md
# mdu_divider

Iterative 32-bit divider that executes the DIV and DIVU operations issued by the instruction controller and returns the quotient and remainder for the LO and HI registers. It sits beside the ALU in the execute path. It accepts a one-cycle start request with latched operands and holds `busy` high while iterating, so the core stalls. It raises a one-cycle `done` pulse when the HI/LO write data is valid.

## Interface
- `WIDTH`, default 32: operand and result width in bits.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: division request; sampled only in IDLE.
- `is_signed` input 1: 1 selects DIV (two's complement), 0 selects DIVU.
- `dividend` input WIDTH: rs operand, latched on an accepted start.
- `divisor` input WIDTH: rt operand, latched on an accepted start.
- `busy` output 1: high from the cycle after an accepted start until `done`; the core stalls the PC while it is high.
- `done` output 1: one-cycle pulse; `quotient`/`remainder` are valid from this cycle on.
- `quotient` output WIDTH: LO write data.
- `remainder` output WIDTH: HI write data.
- `div_by_zero` output 1: latched status of the last operation; 1 if the divisor was 0.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with `start`=1:
  - Latch magnitudes |dividend| and |divisor|; magnitudes apply only when `is_signed`=1.
  - Latch sign flags: `q_neg` = sign(dividend) XOR sign(divisor); `r_neg` = sign(dividend).
  - Clear partial remainder and iteration counter; go to CALC.
- CALC, one restoring step per cycle:
  - Shift the {partial remainder, dividend} pair left by 1.
  - Trial-subtract the divisor magnitude; if there is no borrow, keep the difference and shift in quotient bit 1, otherwise shift in 0.
  - Partial remainder is WIDTH+1 bits to hold the borrow.
  - After WIDTH steps, go to FIX.
- FIX:
  - Apply signs: quotient negated if `q_neg`, remainder negated if `r_neg`.
  - Register results, pulse `done`, go to IDLE.
- Result rules, all to MIPS semantics:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0 (no trap).
  - Divisor 0:
    - Quotient 0xFFFFFFFF, remainder = original dividend, for both signed and unsigned; sign fix is bypassed.
    - `div_by_zero`=1.
- `start` in CALC or FIX is ignored; operands changing while busy have no effect.
- Results and `div_by_zero` hold until the next `done`.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0. Counter and internal registers cleared.
- Edge E0 samples `start`.
- `busy`=1 after E0.
- CALC steps occur at E1..E32 (WIDTH=32).
- FIX resolves at E33: `done`=1 and `busy`=0 after E33. Latency is WIDTH+1 cycles from the start edge.
- `done` is high for exactly one cycle. `start` may be asserted in that same `done` cycle: the unit is already in IDLE, so it is accepted back to back.
- `rst_n` low mid-operation: immediately aborts to IDLE with all outputs at reset values; no `done` is issued for the aborted operation.
- No combinational path from inputs to outputs.

## Configuration
- `MDU_DIV_ZERO_FAST_EN`
  - Defined: a zero divisor is detected in IDLE at the start edge. The unit skips CALC, goes directly to FIX, and `done` arrives after E1 (latency 1).
  - Undefined: a zero divisor runs the full WIDTH+1 cycle sequence. Result values and `div_by_zero` are identical in both builds.

## Test plan
- DIVU 100 / 7 -> `busy` for 33 cycles, `done` at E33, `quotient`=14, `remainder`=2, `div_by_zero`=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> `quotient`=0xFFFFFFFD (-3), `remainder`=0xFFFFFFFF (-1); and DIV 7 / 0xFFFFFFFE -> `quotient`=0xFFFFFFFD, `remainder`=1.
- DIV 0x80000000 / 0xFFFFFFFF -> `quotient`=0x80000000, `remainder`=0; DIVU of the same operands -> `quotient`=0, `remainder`=0x80000000.
- DIV 0x12345678 / 0 -> `quotient`=0xFFFFFFFF, `remainder`=0x12345678, `div_by_zero`=1. `done` after E33 without `MDU_DIV_ZERO_FAST_EN`, after E1 with it.
- Mid-operation disturbances, starting from DIVU 50 / 5:
  - New `start` with operands 9 / 3 at cycle 10 -> ignored; `done` at E33 with `quotient`=10, `remainder`=0.
  - Back-to-back `start` in the `done` cycle -> second result valid 33 cycles later.
- `rst_n` pulsed low at cycle 15 of a DIVU -> `busy`=0 and outputs 0 immediately; no `done`; the next `start` completes normally.
